// File: rtl/dir_cmd_tx.sv
// dir_cmd_tx: debounces the per-frame direction code sampled at the end of the
// active area and sends each newly accepted direction as one UART 8N1 byte.
module dir_cmd_tx #(
    parameter int Y_START       = 27,
    parameter int V_SYNC_ACT    = 600,
    parameter int STABLE_FRAMES = 3,
    parameter int CLKS_PER_BIT  = 347
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic [2:0]  iDirection,
    output logic        oTX,
    output logic        oBusy,
    output logic [2:0]  oStableDir
);

    localparam int              CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [12:0]     STROBE_LINE = 13'(Y_START + V_SYNC_ACT);
    localparam logic [3:0]      RUN_MAX     = 4'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      CODE_NONE   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    tx_state_t state;
    tx_state_t stateNext;

    logic             strobe;
    logic             strobeD;
    logic [2:0]       candidate;
    logic [3:0]       runCnt;
    logic             accept;

    logic             pendValid;
    logic [2:0]       pendCode;
    logic [2:0]       lastSent;

    logic [7:0]       shiftReg;
    logic [2:0]       bitIdx;
    logic [CNT_W-1:0] bitCnt;
    logic             bitDone;
    logic             consume;
    logic             load;

    function automatic logic [7:0] cmdByte(input logic [2:0] code);
        return (code == CODE_NONE) ? 8'h4E : {5'b00110, code};
    endfunction

    assign strobe  = (iV_Cont == STROBE_LINE) && (iH_Cont == 13'd0);
    assign accept  = strobeD && (runCnt == RUN_MAX) && (candidate != oStableDir);
    assign bitDone = (bitCnt == BIT_LAST);
    assign oBusy   = (state != IDLE);

    // Debounce: track a candidate code and how many consecutive frames it held.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            strobeD    <= 1'b0;
            candidate  <= CODE_NONE;
            runCnt     <= '0;
            oStableDir <= CODE_NONE;
        end else begin
            strobeD <= strobe;
            if (strobe) begin
                if (iDirection == candidate) begin
                    if (runCnt < RUN_MAX) runCnt <= runCnt + 4'd1;
                end else begin
                    candidate <= iDirection;
                    runCnt    <= 4'd1;
                end
            end
            if (accept) oStableDir <= candidate;
        end
    end

    // Single-entry command slot; a post beats a same-cycle consume so it is not lost.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pendValid <= 1'b0;
            pendCode  <= CODE_NONE;
        end else if (accept) begin
            pendValid <= 1'b1;
            pendCode  <= candidate;
        end else if (consume) begin
            pendValid <= 1'b0;
        end
    end

    // TX state register plus bit timing and shift datapath.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitIdx   <= '0;
            bitCnt   <= '0;
            lastSent <= CODE_NONE;
        end else begin
            state <= stateNext;
            if (load) begin
                shiftReg <= cmdByte(pendCode);
                lastSent <= pendCode;
                bitIdx   <= '0;
                bitCnt   <= '0;
            end else if (state != IDLE) begin
                if (bitDone) begin
                    bitCnt <= '0;
                    if (state == DATA) bitIdx <= bitIdx + 3'd1;
                end else begin
                    bitCnt <= bitCnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic; a pending code equal to the last sent one is discarded
    // because an overwrite can bring the line back to the code just transmitted.
    always_comb begin
        stateNext = state;
        consume   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pendValid) begin
                    consume = 1'b1;
                    if (pendCode != lastSent) begin
                        load      = 1'b1;
                        stateNext = START;
                    end
                end
            end
            START: if (bitDone) stateNext = DATA;
            DATA:  if (bitDone && (bitIdx == 3'd7)) stateNext = STOP;
            STOP:  if (bitDone) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Serial line level for the current state.
    always_comb begin
        oTX = 1'b1;
        case (state)
            START:   oTX = 1'b0;
            DATA:    oTX = shiftReg[bitIdx];
            default: oTX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dir_cmd_tx.sv
// tb_dir_cmd_tx: directed checks of debounce, UART framing, overwrite and reset.
`timescale 1ns/1ps
module tb_dir_cmd_tx;

    localparam logic [12:0] STROBE_V = 13'd627;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [12:0] iH_Cont;
    logic [12:0] iV_Cont;
    logic [2:0]  dirA;
    logic [2:0]  dirB;
    logic        txA, busyA, txB, busyB;
    logic [2:0]  stableA, stableB;

    int checks = 0;
    int errors = 0;
    int startsA = 0;
    int startsB = 0;
    int txLowA = 0;
    logic busyAPrev = 1'b0;
    logic busyBPrev = 1'b0;

    dir_cmd_tx u_slow (
        .iCLK(iCLK), .iRST_N(iRST_N), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
        .iDirection(dirA), .oTX(txA), .oBusy(busyA), .oStableDir(stableA)
    );

    dir_cmd_tx #(.STABLE_FRAMES(1), .CLKS_PER_BIT(4)) u_fast (
        .iCLK(iCLK), .iRST_N(iRST_N), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
        .iDirection(dirB), .oTX(txB), .oBusy(busyB), .oStableDir(stableB)
    );

    always #5 iCLK = ~iCLK;

    // Count byte starts and low line samples on the falling edge.
    always @(negedge iCLK) begin
        if (busyA === 1'b1 && busyAPrev === 1'b0) startsA++;
        if (busyB === 1'b1 && busyBPrev === 1'b0) startsB++;
        if (txA === 1'b0) txLowA++;
        busyAPrev = busyA;
        busyBPrev = busyB;
    end

    function automatic logic tx_of(input bit fast);
        return fast ? txB : txA;
    endfunction

    function automatic logic busy_of(input bit fast);
        return fast ? busyB : busyA;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [2:0] dA, input logic [2:0] dB, input int gap);
        dirA = dA;
        dirB = dB;
        iV_Cont = STROBE_V;
        iH_Cont = 13'd0;
        @(negedge iCLK);
        iV_Cont = 13'd0;
        iH_Cont = 13'd1;
        repeat (gap) @(negedge iCLK);
    endtask

    // Wait (bounded) for a start bit, then decode one frame mid-bit and time oBusy.
    task automatic rx_byte(input bit fast, input int cpb, input int limit,
                           output logic [7:0] data, output int busyLen,
                           output logic found, output logic frameOk);
        int n;
        logic sBit, pBit;
        data = '0; busyLen = 0; found = 1'b0; frameOk = 1'b0; n = 0;
        sBit = 1'b1; pBit = 1'b0;
        while (tx_of(fast) !== 1'b0 && n < limit) begin
            @(negedge iCLK);
            n++;
        end
        if (tx_of(fast) !== 1'b0) return;
        found = 1'b1;
        for (int i = 0; i < 12 * cpb; i++) begin
            if (busy_of(fast) !== 1'b1) break;
            busyLen++;
            if (i % cpb == cpb / 2) begin
                if (i / cpb == 0) sBit = tx_of(fast);
                else if (i / cpb <= 8) data[3'(i / cpb - 1)] = tx_of(fast);
                else if (i / cpb == 9) pBit = tx_of(fast);
            end
            @(negedge iCLK);
        end
        frameOk = (sBit === 1'b0) && (pBit === 1'b1);
    endtask

    logic [7:0] d;
    int         len;
    logic       found, fr;
    int         s0, l0;

    initial begin
        iRST_N = 1'b0; iH_Cont = 13'd1; iV_Cont = 13'd0; dirA = 3'd7; dirB = 3'd7;
        repeat (3) @(negedge iCLK);
        check("rst_txA", 32'(txA), 32'd1);
        check("rst_busyA", 32'(busyA), 32'd0);
        check("rst_stableA", 32'(stableA), 32'd7);
        check("rst_txB", 32'(txB), 32'd1);
        check("rst_busyB", 32'(busyB), 32'd0);
        check("rst_stableB", 32'(stableB), 32'd7);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // No motion: code 7 never produces output.
        s0 = startsA; l0 = txLowA;
        repeat (5) strobe(3'd7, 3'd7, 8);
        repeat (50) @(negedge iCLK);
        check("nomotion_starts", 32'(startsA - s0), 32'd0);
        check("nomotion_txlow", 32'(txLowA - l0), 32'd0);
        check("nomotion_stable", 32'(stableA), 32'd7);

        // Then code 0 for three frames sends '0'.
        fork
            repeat (3) strobe(3'd0, 3'd7, 8);
            rx_byte(1'b0, 347, 200, d, len, found, fr);
        join
        check("zero_found", 32'(found), 32'd1);
        check("zero_byte", 32'(d), 32'h30);
        check("zero_busylen", 32'(len), 32'd3470);
        check("zero_frame", 32'(fr), 32'd1);
        check("zero_stable", 32'(stableA), 32'd0);

        // Debounce 3,3,3 with acceptance one cycle after the third strobe.
        strobe(3'd3, 3'd7, 8);
        strobe(3'd3, 3'd7, 8);
        check("deb_two_frames", 32'(stableA), 32'd0);
        strobe(3'd3, 3'd7, 0);
        check("deb_strobe_cycle", 32'(stableA), 32'd0);
        @(negedge iCLK);
        check("deb_accept", 32'(stableA), 32'd3);
        rx_byte(1'b0, 347, 20, d, len, found, fr);
        check("deb_found", 32'(found), 32'd1);
        check("deb_byte", 32'(d), 32'h33);
        check("deb_busylen", 32'(len), 32'd3470);
        check("deb_frame", 32'(fr), 32'd1);

        // Glitch: 1,1,5,1,1 is not enough; a third consecutive 1 is.
        s0 = startsA;
        strobe(3'd1, 3'd7, 8);
        strobe(3'd1, 3'd7, 8);
        strobe(3'd5, 3'd7, 8);
        strobe(3'd1, 3'd7, 8);
        strobe(3'd1, 3'd7, 8);
        repeat (20) @(negedge iCLK);
        check("glitch_stable", 32'(stableA), 32'd3);
        check("glitch_starts", 32'(startsA - s0), 32'd0);
        strobe(3'd1, 3'd7, 0);
        rx_byte(1'b0, 347, 20, d, len, found, fr);
        check("glitch_byte", 32'(d), 32'h31);
        check("glitch_stable_after", 32'(stableA), 32'd1);

        // No repeat: holding 1 for ten more frames sends nothing.
        s0 = startsA;
        repeat (10) strobe(3'd1, 3'd7, 8);
        repeat (20) @(negedge iCLK);
        check("norepeat_starts", 32'(startsA - s0), 32'd0);
        check("norepeat_stable", 32'(stableA), 32'd1);

        // Reset during data bit 4 of 0x32.
        strobe(3'd2, 3'd7, 8);
        strobe(3'd2, 3'd7, 8);
        strobe(3'd2, 3'd7, 0);
        begin
            int n = 0;
            while (txA !== 1'b0 && n < 20) begin
                @(negedge iCLK);
                n++;
            end
        end
        check("rstmid_started", 32'(txA), 32'd0);
        repeat (5 * 347 + 100) @(negedge iCLK);
        check("rstmid_busy_before", 32'(busyA), 32'd1);
        check("rstmid_bit4", 32'(txA), 32'd1);
        iRST_N = 1'b0;
        #1;
        check("rstmid_tx", 32'(txA), 32'd1);
        check("rstmid_busy", 32'(busyA), 32'd0);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        l0 = txLowA;
        repeat (4000) @(negedge iCLK);
        check("rstmid_idle", 32'(txLowA - l0), 32'd0);
        check("rstmid_stable", 32'(stableA), 32'd7);
        check("rstmid_busy_after", 32'(busyA), 32'd0);

        // Overwrite on the fast instance: 2,4,6 five cycles apart -> 0x32 then 0x36.
        fork
            begin
                strobe(3'd7, 3'd2, 4);
                strobe(3'd7, 3'd4, 4);
                strobe(3'd7, 3'd6, 4);
            end
            begin
                rx_byte(1'b1, 4, 50, d, len, found, fr);
                check("ovw_first_byte", 32'(d), 32'h32);
                check("ovw_first_len", 32'(len), 32'd40);
                rx_byte(1'b1, 4, 50, d, len, found, fr);
                check("ovw_second_byte", 32'(d), 32'h36);
                check("ovw_second_len", 32'(len), 32'd40);
                check("ovw_second_frame", 32'(fr), 32'd1);
            end
        join
        s0 = startsB;
        repeat (100) @(negedge iCLK);
        check("ovw_no_third", 32'(startsB - s0), 32'd0);
        check("ovw_stable", 32'(stableB), 32'd6);

        // A pending code overwritten back to the code just sent is not resent.
        fork
            begin
                strobe(3'd7, 3'd3, 4);
                strobe(3'd7, 3'd5, 4);
                strobe(3'd7, 3'd3, 4);
            end
            begin
                rx_byte(1'b1, 4, 50, d, len, found, fr);
                check("dedup_byte", 32'(d), 32'h33);
            end
        join
        s0 = startsB;
        repeat (100) @(negedge iCLK);
        check("dedup_no_resend", 32'(startsB - s0), 32'd0);
        check("dedup_stable", 32'(stableB), 32'd3);
        check("dedup_idle", 32'(txB), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
